// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
//   Board-level constants shared by the input front end and its users.
//   - CLK_HZ / DEBOUNCE_MS : clock rate and debounce window. The top level
//     derives its default debounce cycle count from these.
//   - SW0..SW3, BTNC       : bit positions of each input in the conditioned
//     vector.
//   - chan_out_t           : bundle of per-channel conditioned outputs.
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Default channel mapping: slide switches first, centre button on top.
    localparam int SW0  = 0;
    localparam int SW1  = 1;
    localparam int SW2  = 2;
    localparam int SW3  = 3;
    localparam int BTNC = 4;

    // Conditioned view of one input channel.
    typedef struct packed {
        logic level;   // debounced stable level
        logic rise;    // one-cycle pulse on accepted 0->1
        logic fall;    // one-cycle pulse on accepted 1->0
        logic toggle;  // flips on every accepted rise
    } chan_out_t;

    // Number of clock cycles in a debounce window of 'ms' milliseconds.
    function automatic int debounce_cycles(input int clk_hz, input int ms);
        return clk_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One input bit: two-flop synchronizer, stability counter, debounced level,
//   registered rise/fall pulses and a toggle that flips on every rise.
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive cycles the synchronized input must differ
//                       from the current level before it is accepted (>= 2)
//     RESET_LEVEL     : value of the synchronizer and level during reset
//   Ports
//     clk_i   : system clock
//     rst_ni  : asynchronous active-low reset
//     raw_i   : unsynchronized pin value
//     out_o   : conditioned outputs (level/rise/fall/toggle), all registered
// -----------------------------------------------------------------------------
module debounce_channel
    import board_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 1_000_000,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      raw_i,
    output chan_out_t out_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    // Counter only ever reaches DEBOUNCE_CYCLES-1, which always fits in CNT_W.
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             level_q,  level_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             toggle_q, toggle_d;

    // Stability counter: counts consecutive cycles where the synchronized
    // input disagrees with the accepted level. Any agreement (bounce back)
    // restarts it. The cycle that would make it reach DEBOUNCE_CYCLES
    // instead commits the new level and fires the matching pulse.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        toggle_d = toggle_q;

        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d    = '0;
            level_d  = sync2_q;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
            toggle_d = toggle_q ^ sync2_q;   // only a rise flips it
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            cnt_q    <= '0;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            toggle_q <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            toggle_q <= toggle_d;
        end
    end

    assign out_o.level  = level_q;
    assign out_o.rise   = rise_q;
    assign out_o.fall   = fall_q;
    assign out_o.toggle = toggle_q;

endmodule

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
//   Front end for the board's slide switches and push buttons. Each raw pin is
//   synchronized to CLK100MHZ and debounced independently; channels never
//   interact, so several may pulse on the same edge. All outputs are
//   registered - there is no combinational path from raw_in.
//
//   Parameters
//     N_IN            : number of channels (default SW[3:0] + BTNC at bit 4)
//     DEBOUNCE_CYCLES : hold time in cycles before a new value is accepted
//                       (default 10 ms at 100 MHz; must be >= 2)
//     RESET_LEVEL     : per-channel level held during and after reset
//   Ports
//     CLK100MHZ  : system clock
//     CPU_RESETN : asynchronous active-low reset
//     raw_in     : unsynchronized pin values
//     level      : debounced stable levels
//     rise, fall : one-cycle pulses on accepted level changes
//     toggle     : per-channel state flipped by every rise
// -----------------------------------------------------------------------------
module input_conditioner
    import board_pkg::*;
#(
    parameter int              N_IN            = 5,
    parameter int              DEBOUNCE_CYCLES = debounce_cycles(CLK_HZ, DEBOUNCE_MS),
    parameter logic [N_IN-1:0] RESET_LEVEL     = '0
) (
    input  logic            CLK100MHZ,
    input  logic            CPU_RESETN,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] rise,
    output logic [N_IN-1:0] fall,
    output logic [N_IN-1:0] toggle
);

    chan_out_t ch_out [N_IN];

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[i])
        ) u_ch (
            .clk_i  (CLK100MHZ),
            .rst_ni (CPU_RESETN),
            .raw_i  (raw_in[i]),
            .out_o  (ch_out[i])
        );

        assign level[i]  = ch_out[i].level;
        assign rise[i]   = ch_out[i].rise;
        assign fall[i]   = ch_out[i].fall;
        assign toggle[i] = ch_out[i].toggle;
    end

endmodule
